// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with fixed-priority encoder and claim/complete FSM.
// Define IRQ_CTRL_EDGE_EN for rising-edge pending capture; the default build is level-sensitive.

module irq_ctrl #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  input  logic [3:0]         sel_i,
  input  logic               we_i,
  input  logic               re_i,
  output logic [31:0]        data_o,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

  state_e             state_q, state_d;
  logic [4:0]         in_service_q, in_service_d;
  logic               gen_q, gen_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [31:0]        data_q, data_d;

  logic [NUM_SRC-1:0] lane_mask, active, set_vec, wr_clr, claim_clr;
  logic [4:0]         irq_id;
  logic [4:0]         id_chain [NUM_SRC+1];
  logic [31:0]        rdata;
  logic               sel_ctrl, sel_en, sel_pend, sel_claim;
  logic               ctrl_wr, gen_clear, en_wr, pend_wr, claim, complete;

  assign sel_ctrl  = (addr_i[3:0] == 4'h0);
  assign sel_en    = (addr_i[3:0] == 4'h4);
  assign sel_pend  = (addr_i[3:0] == 4'h8);
  assign sel_claim = (addr_i[3:0] == 4'hC);

  assign ctrl_wr   = we_i & sel_ctrl & sel_i[0];
  assign gen_clear = ctrl_wr & ~data_i[0];
  assign en_wr     = we_i & sel_en;
  assign pend_wr   = we_i & sel_pend;
  assign claim     = re_i & sel_claim & (state_q == StAssert);
  assign complete  = we_i & sel_claim & (state_q == StService) & (data_i[4:0] == in_service_q);

  assign active = pending_q & enable_q;

  // Chain runs from the top index down so the lowest active index wins.
  assign id_chain[NUM_SRC] = '0;
  for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
    assign lane_mask[n] = sel_i[n/8];
    assign id_chain[n]  = active[n] ? 5'(n + 1) : id_chain[n+1];
    assign claim_clr[n] = claim & (irq_id == 5'(n + 1));
  end
  assign irq_id   = id_chain[0];
  assign irq_id_o = irq_id;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] src_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_prev_q <= '0;
    end else begin
      src_prev_q <= src_i;
    end
  end

  assign set_vec = src_i & ~src_prev_q;
`else
  assign set_vec = src_i;
`endif

  assign wr_clr = {NUM_SRC{pend_wr}} & lane_mask & data_i[NUM_SRC-1:0];

  // A new request outranks any clear of the same bit in the same cycle.
  always_comb begin
    gen_d     = ctrl_wr ? data_i[0] : gen_q;
    enable_d  = en_wr ? ((enable_q & ~lane_mask) | (data_i[NUM_SRC-1:0] & lane_mask)) : enable_q;
    pending_d = (pending_q & ~(wr_clr | claim_clr)) | set_vec;
  end

  // Read data reflects register values before any write in the same cycle.
  always_comb begin
    rdata = '0;
    case (addr_i[3:0])
      4'h0:    rdata = {31'b0, gen_q};
      4'h4:    rdata = 32'(enable_q);
      4'h8:    rdata = 32'(pending_q);
      4'hC:    rdata = (state_q == StAssert) ? 32'(irq_id) : '0;
      default: rdata = '0;
    endcase
    data_d = re_i ? rdata : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q     <= 1'b0;
      enable_q  <= '0;
      pending_q <= '0;
      data_q    <= '0;
    end else begin
      gen_q     <= gen_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign data_o = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_service_d = in_service_q;
    if (gen_clear) begin
      state_d      = StIdle;
      in_service_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gen_q && (irq_id != '0)) state_d = StAssert;
        end
        StAssert: begin
          if (claim) begin
            state_d      = StService;
            in_service_d = irq_id;
          end else if ((irq_id == '0) || !gen_q) begin
            state_d = StIdle;
          end
        end
        StService: begin
          if (complete) begin
            state_d      = StIdle;
            in_service_d = '0;
          end
        end
        default: begin
          state_d      = StIdle;
          in_service_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    irq_o = (state_q == StAssert);
  end

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], data_i[31:NUM_SRC], sel_i};

endmodule
